// File: rtl/aes_spi_slave_port.sv
// SPI-style slave front end for an AES core: shifts in key and block,
// starts the core, and shifts the captured result back out on miso.
module aes_spi_slave_port #(
    parameter int NK         = 4,
    parameter int TURNAROUND = 56
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic [NK*32-1:0]  key_out,
    output logic [127:0]      block_out,
    output logic              start,
    input  logic [127:0]      result_in,
    input  logic              result_valid,
    output logic              busy,
    output logic              late_err
);

    localparam int KB = NK * 32;
    localparam int TW = $clog2(TURNAROUND + 1);

    typedef enum logic [2:0] {
        IDLE,
        RX_KEY,
        RX_BLK,
        WAIT,
        TX,
        DONE
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [8:0]     cnt;
    logic [TW-1:0]  tcnt;
    logic [127:0]   tx;
    logic           captured;

    logic           take;
    logic           key_last;
    logic           blk_last;
    logic           expire;
    logic           cap_now;

    always_comb begin
        state_n  = state;
        take     = 1'b0;
        key_last = 1'b0;
        blk_last = 1'b0;
        expire   = 1'b0;
        cap_now  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!cs) begin
                    take    = 1'b1;
                    state_n = RX_KEY;
                end
            end
            RX_KEY: begin
                if (cs) begin
                    state_n = IDLE;
                end else begin
                    take = 1'b1;
                    if (cnt == 9'(KB - 1)) begin
                        key_last = 1'b1;
                        state_n  = RX_BLK;
                    end
                end
            end
            RX_BLK: begin
                if (cs) begin
                    state_n = IDLE;
                end else begin
                    take = 1'b1;
                    if (cnt == 9'd127) begin
                        blk_last = 1'b1;
                        state_n  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cs) begin
                    state_n = IDLE;
                end else begin
                    // the start cycle cannot carry a real result
                    cap_now = result_valid && !start;
                    if (tcnt == '0) begin
                        expire  = 1'b1;
                        state_n = TX;
                    end
                end
            end
            TX: begin
                if (cs) begin
                    state_n = IDLE;
                end else if (cnt == 9'd127) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (cs) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            tcnt      <= '0;
            tx        <= '0;
            captured  <= 1'b0;
            start     <= 1'b0;
            late_err  <= 1'b0;
            key_out   <= '0;
            block_out <= '0;
        end else begin
            start <= blk_last;

            if (state == IDLE) begin
                cnt <= take ? 9'd1 : 9'd0;
            end else if (key_last || blk_last) begin
                cnt <= '0;
            end else if (take || (state == TX && !cs)) begin
                cnt <= cnt + 9'd1;
            end

            if (take) begin
                if (state == RX_BLK) begin
                    block_out <= {block_out[126:0], mosi};
                end else begin
                    key_out <= {key_out[KB-2:0], mosi};
                end
            end

            if (state == IDLE && !cs) begin
                late_err <= 1'b0;
                captured <= 1'b0;
            end

            if (blk_last) begin
                tcnt     <= TW'(TURNAROUND - 1);
                captured <= 1'b0;
            end else if (state == WAIT && tcnt != '0) begin
                tcnt <= tcnt - 1'b1;
            end

            if (cap_now) begin
                tx       <= result_in;
                captured <= 1'b1;
            end else if (expire && !captured) begin
                tx       <= '0;
                late_err <= 1'b1;
            end

            if (state == TX && !cs) begin
                tx <= {tx[126:0], 1'b0};
            end
        end
    end

    assign miso = (state == TX) && tx[127];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_aes_spi_slave_port.sv
// Bench for aes_spi_slave_port: NK=6 and NK=4 instances sharing the bus,
// vector table of full frames plus abort, async reset and DONE-hold cases.
module tb_aes_spi_slave_port;

    localparam int T = 56;

    logic         clk = 1'b0;
    logic         reset;
    logic         cs;
    logic         mosi;
    logic         sel;
    logic [127:0] res;
    int           dly;

    logic         cs6, miso6, start6, busy6, late6, rv6;
    logic [191:0] key6;
    logic [127:0] blk6;
    logic         cs4, miso4, start4, busy4, late4, rv4;
    logic [127:0] key4;
    logic [127:0] blk4;

    int dc6, dc4, st6, st4;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         nk4;
        logic [255:0] key;
        logic [127:0] blk;
        logic [127:0] res;
        int           dly;
        logic [127:0] exp;
        logic         late;
        int           hold;
    } vec_t;

    vec_t         v[5];
    logic [127:0] exp_q[$];
    logic [127:0] last_blk6;

    always #5 clk = ~clk;

    assign cs6 = sel ? 1'b1 : cs;
    assign cs4 = sel ? cs : 1'b1;

    aes_spi_slave_port #(.NK(6), .TURNAROUND(T)) dut6 (
        .clk(clk), .reset(reset), .cs(cs6), .mosi(mosi), .miso(miso6),
        .key_out(key6), .block_out(blk6), .start(start6),
        .result_in(res), .result_valid(rv6), .busy(busy6), .late_err(late6)
    );

    aes_spi_slave_port #(.NK(4), .TURNAROUND(T)) dut4 (
        .clk(clk), .reset(reset), .cs(cs4), .mosi(mosi), .miso(miso4),
        .key_out(key4), .block_out(blk4), .start(start4),
        .result_in(res), .result_valid(rv4), .busy(busy4), .late_err(late4)
    );

    logic         miso_m, start_m, busy_m, late_m;
    logic [255:0] key_m;
    logic [127:0] blk_m;
    assign miso_m  = sel ? miso4 : miso6;
    assign start_m = sel ? start4 : start6;
    assign busy_m  = sel ? busy4 : busy6;
    assign late_m  = sel ? late4 : late6;
    assign key_m   = sel ? {128'b0, key4} : {64'b0, key6};
    assign blk_m   = sel ? blk4 : blk6;

    // core models: one result_valid pulse a fixed delay after start
    always @(posedge clk) begin
        if (reset) begin
            dc6 <= 0;
            rv6 <= 1'b0;
        end else begin
            rv6 <= 1'b0;
            if (dc6 > 0) begin
                dc6 <= dc6 - 1;
                if (dc6 == 1) rv6 <= 1'b1;
            end
            if (start6) dc6 <= dly;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            dc4 <= 0;
            rv4 <= 1'b0;
        end else begin
            rv4 <= 1'b0;
            if (dc4 > 0) begin
                dc4 <= dc4 - 1;
                if (dc4 == 1) rv4 <= 1'b1;
            end
            if (start4) dc4 <= dly;
        end
    end

    always @(posedge clk) begin
        if (start6) st6 <= st6 + 1;
        if (start4) st4 <= st4 + 1;
    end

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive_bits(input vec_t t, input int n);
        int kb;
        kb = t.nk4 ? 128 : 192;
        for (int i = 0; i < n; i++) begin
            cs   = 1'b0;
            mosi = (i < kb) ? t.key[kb-1-i] : t.blk[127-(i-kb)];
            @(negedge clk);
            if (i == 0) chk("late_clr", late_m, 0);
            if (i == kb + 126) chk("start_pre", start_m, 0);
        end
    endtask

    task automatic run_frame(input vec_t t);
        int           s0;
        logic         quiet;
        logic         bad;
        logic [127:0] got;
        sel = t.nk4;
        res = t.res;
        dly = t.dly;
        s0  = sel ? st4 : st6;
        drive_bits(t, (t.nk4 ? 128 : 192) + 128);
        exp_q.push_back(t.exp);
        if (!t.nk4) last_blk6 = t.blk;
        chk("start", start_m, 1);
        chk("key", key_m, t.key);
        chk("block", blk_m, t.blk);
        quiet = 1'b0;
        for (int k = 0; k < T; k++) begin
            if (k > 0) @(negedge clk);
            mosi  = 1'($urandom);
            quiet = quiet | miso_m;
        end
        chk("quiet", quiet, 0);
        got = '0;
        for (int b = 0; b < 128; b++) begin
            @(negedge clk);
            mosi = 1'($urandom);
            got  = {got[126:0], miso_m};
        end
        chk("result", got, exp_q.pop_front());
        chk("late", late_m, t.late);
        @(negedge clk);
        chk("done_miso", miso_m, 0);
        chk("done_busy", busy_m, 1);
        bad = 1'b0;
        for (int h = 0; h < t.hold; h++) begin
            @(negedge clk);
            mosi = 1'($urandom);
            bad  = bad | miso_m | !busy_m;
        end
        chk("hold", bad, 0);
        chk("one_start", (sel ? st4 : st6) - s0, 1);
        cs = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy_m, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        int s0;
        v[0] = '{1'b0,
                 256'h000102030405060708090a0b0c0d0e0f1011121314151617,
                 128'h00112233445566778899aabbccddeeff,
                 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 20,
                 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b0, 5};
        v[1] = '{1'b1,
                 256'h000102030405060708090a0b0c0d0e0f,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                 128'h00112233445566778899aabbccddeeff, 20,
                 128'h00112233445566778899aabbccddeeff, 1'b0, 0};
        v[2] = '{1'b0,
                 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f00112233445566778,
                 128'h3243f6a8885a308d313198a2e0370734,
                 128'h3925841d02dc09fbdc118597196a0b32, 60,
                 128'h0, 1'b1, 0};
        // result arrives on the very cycle the turnaround expires
        v[3] = '{1'b0,
                 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                 128'h6bc1bee22e409f96e93d7e117393172a,
                 128'hbd334f1d6e45f25ff712a214571fa5cc, 54,
                 128'hbd334f1d6e45f25ff712a214571fa5cc, 1'b0, 20};
        // one cycle too late
        v[4] = '{1'b0,
                 256'h000102030405060708090a0b0c0d0e0f1011121314151617,
                 128'hffeeddccbbaa99887766554433221100,
                 128'h0123456789abcdeffedcba9876543210, 55,
                 128'h0, 1'b1, 0};

        st6 = 0; st4 = 0;
        reset = 1'b1; cs = 1'b1; mosi = 1'b0; sel = 1'b0;
        res = '0; dly = 20;
        repeat (3) @(negedge clk);
        chk("rst_miso", miso6, 0);
        chk("rst_busy", busy6, 0);
        chk("rst_start", start6, 0);
        chk("rst_late", late6, 0);
        chk("rst_key", key6, 0);
        chk("rst_blk", blk6, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_frame(v[i]);

        sel = 1'b0;
        s0  = st6;
        drive_bits(v[0], 200);
        cs = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy6, 0);
        repeat (80) @(negedge clk);
        chk("abort_nostart", st6 - s0, 0);
        chk("abort_key", key6, v[0].key);
        chk("abort_blk", blk6, {last_blk6[119:0], v[0].blk[127:120]});
        run_frame(v[0]);

        sel = 1'b0;
        res = v[0].res;
        dly = v[0].dly;
        drive_bits(v[0], 320);
        repeat (T) @(negedge clk);
        chk("pre_rst_miso", miso6, 1);
        chk("pre_rst_busy", busy6, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_miso", miso6, 0);
        chk("arst_busy", busy6, 0);
        chk("arst_start", start6, 0);
        chk("arst_key", key6, 0);
        #3;
        reset = 1'b0;
        cs = 1'b1;
        @(negedge clk);
        run_frame(v[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_spi_slave_port.md
Name: aes_spi_slave_port

Overview:
- SPI-style slave front end for an AES core; the bus-side counterpart of the test master that drives key and text frames.
- Deserialises a key (NK*32 bits) and a 128-bit block from mosi, starts the attached encryption or decryption core, and captures its 128-bit result.
- After a fixed turnaround it serialises the result back on miso, MSB first.
- Everything runs in one clk domain; cs is treated as a synchronous level input.

Parameters:
- NK, 4, key length in 32-bit words: 4, 6 or 8.
- TURNAROUND, 56, clk cycles from the last block bit to the first result bit on miso; must be at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  chip select, active low; frame framing.
- mosi  in  1  serial data from master, MSB first; sampled on rising clk when cs=0.
- miso  out  1  serial result to master, MSB first; changes on rising clk; master samples it on the falling edge.
- key_out  out  NK*32  received key, held stable from start until the next frame's first key bit.
- block_out  out  128  received block, same hold rule as key_out.
- start  out  1  one-cycle pulse to the core after the 128th block bit.
- result_in  in  128  core output.
- result_valid  in  1  core result strobe; result_in is captured on the cycle it is high.
- busy  out  1  high in every state except IDLE.
- late_err  out  1  sticky; set when the result was not captured before transmit began. Cleared by reset or at the next frame start.

Behaviour:
- Reset (async) forces all outputs to 0:
  - miso, start, busy, late_err, key_out, block_out all 0; FSM enters IDLE.
  - Bit counter and turnaround counter are cleared.
- FSM states: IDLE, RX_KEY, RX_BLK, WAIT, TX, DONE.
- IDLE:
  - If cs=0, the first key bit is sampled in this same cycle. key_out shifts left with mosi into the LSB, bit counter is set to 1, late_err is cleared, and the FSM goes to RX_KEY.
  - A frame therefore needs no idle preamble.
- RX_KEY:
  - Each cycle with cs=0, shift mosi into key_out and increment the counter.
  - When the NK*32-th bit is taken, clear the counter and go to RX_BLK.
- RX_BLK:
  - Same shifting into block_out.
  - On the 128th bit, assert start for exactly one cycle (the next cycle), load the turnaround counter, and go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - When result_valid=1, latch result_in into the tx shift register and set captured. result_valid in any other state is ignored.
  - When the counter expires (TURNAROUND cycles after the last block bit), go to TX and drive miso=tx[127].
  - If nothing was captured by then, set late_err and transmit all zeros.
- TX:
  - On each rising edge, shift tx left and present the next bit.
  - After exactly 128 bits have been presented, go to DONE with miso=0.
- DONE:
  - miso=0 and mosi is ignored.
  - Return to IDLE only when cs=1. A new frame needs cs high for at least one cycle.
- Abort: cs=1 in RX_KEY, RX_BLK, WAIT or TX means:
  - Go to IDLE immediately and set miso=0.
  - No start pulse if the block was incomplete.
  - A pending result is discarded.
  - key_out and block_out keep their partial contents.
- Simultaneous events:
  - result_valid on the same cycle the turnaround counter expires still counts as captured, and that value is transmitted.
  - result_valid on the same cycle as start is not possible by construction and is ignored.
- miso is 0 in every state except TX.

Test Plan:
- NK=6. Key 000102030405060708090a0b0c0d0e0f1011121314151617, text 00112233445566778899aabbccddeeff. Core model returns dda97ca4864cdfe06eaf70a0ec0d7191 20 cycles after start.
  - Required: start pulses once, one cycle after bit 320.
  - key_out and block_out match the sent values.
  - miso streams dda97ca4… beginning 56 cycles after the last mosi bit.
  - late_err=0.
- NK=4, decryption model. Send key 000102030405060708090a0b0c0d0e0f and block 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: miso returns 00112233445566778899aabbccddeeff over exactly 128 cycles, then miso=0 in DONE.
- Late core: result_valid asserted 60 cycles after start, with TURNAROUND=56.
  - Required: late_err=1, all 128 miso bits are 0.
  - The next frame start clears late_err.
- Abort: raise cs after 200 of the 320 bits.
  - Required: no start pulse, FSM back in IDLE, busy=0.
  - A following full frame completes correctly.
- Async reset asserted mid-TX, asynchronous to clk.
  - Required: miso, busy and start go to 0 without waiting for a clock edge.
  - After reset release, a full frame works.
- cs held low after TX.
  - Required: DONE holds miso=0 and ignores mosi.
  - cs high for one cycle, then low, starts a new frame.
